// File: rtl/button_conditioner.sv
// Debounces N_BTNS bouncing push-buttons and optionally emits a one-clock press pulse.
// Optional feature macro: BTN_ONESHOT_EN (enables btns_pulse; otherwise it is tied to 0).
module button_conditioner #(
    parameter int N_BTNS    = 5,
    parameter int DB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTNS-1:0] btns_raw,
    output logic [N_BTNS-1:0] btns_level,
    output logic [N_BTNS-1:0] btns_pulse,
    output logic              btns_any
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_BTNS-1:0] sync1;
    logic [N_BTNS-1:0] sync2;
    state_t            state [N_BTNS];
    logic [CW-1:0]     cnt   [N_BTNS];
`ifdef BTN_ONESHOT_EN
    logic [N_BTNS-1:0] pulse;
`endif

    // Two-flop synchronizer; sync2 is the sampled button value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btns_raw;
            sync2 <= sync1;
        end
    end

    // Per-channel debounce FSMs; cnt counts consecutive samples that disagree with the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTNS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            btns_level <= '0;
`ifdef BTN_ONESHOT_EN
            pulse      <= '0;
`endif
        end else begin
`ifdef BTN_ONESHOT_EN
            pulse <= '0;
`endif
            for (int i = 0; i < N_BTNS; i++) begin
                case (state[i])
                    IDLE: begin
                        if (sync2[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end else begin
                            cnt[i]   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2[i]) begin
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]      <= PRESSED;
                            cnt[i]        <= '0;
                            btns_level[i] <= 1'b1;
`ifdef BTN_ONESHOT_EN
                            pulse[i]      <= 1'b1;
`endif
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!sync2[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= CNT_ONE;
                        end else begin
                            cnt[i]   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2[i]) begin
                            state[i] <= PRESSED;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]      <= IDLE;
                            cnt[i]        <= '0;
                            btns_level[i] <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i]      <= IDLE;
                        cnt[i]        <= '0;
                        btns_level[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BTN_ONESHOT_EN
    assign btns_pulse = pulse;
`else
    assign btns_pulse = '0;
`endif

    assign btns_any = |btns_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (N_BTNS=5, DB_CYCLES=4), directed scenarios
// plus randomized traffic against a run-length reference model.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
`ifdef BTN_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btns_raw;
    logic [N-1:0] btns_level;
    logic [N-1:0] btns_pulse;
    logic         btns_any;

    int total = 0;
    int bad   = 0;

    button_conditioner #(.N_BTNS(N), .DB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btns_raw   (btns_raw),
        .btns_level (btns_level),
        .btns_pulse (btns_pulse),
        .btns_any   (btns_any)
    );

    always #5 clk = ~clk;

    // Reference model: raw is seen two clocks late; a level flips after DB consecutive disagreeing samples.
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;
    logic [N-1:0] exp_level = '0;
    logic [N-1:0] exp_pulse = '0;
    int           run [N];

    always @(posedge clk) begin : model
        logic [N-1:0] nl;
        logic [N-1:0] np;
        if (rst) begin
            m_s1      <= '0;
            m_s2      <= '0;
            exp_level <= '0;
            exp_pulse <= '0;
            for (int i = 0; i < N; i++) run[i] <= 0;
        end else begin
            nl = exp_level;
            np = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] != exp_level[i]) begin
                    if (run[i] == DB - 1) begin
                        nl[i] = ~exp_level[i];
                        np[i] = ONESHOT & ~exp_level[i];
                        run[i] <= 0;
                    end else begin
                        run[i] <= run[i] + 1;
                    end
                end else begin
                    run[i] <= 0;
                end
            end
            exp_level <= nl;
            exp_pulse <= np;
            m_s2      <= m_s1;
            m_s1      <= btns_raw;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        btns_raw = N'($urandom);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (btns_level !== 5'b00000 || btns_pulse !== 5'b00000 || btns_any !== 1'b0) begin
                bad++;
                $display("FAIL reset: level=%b pulse=%b any=%b want 00000/00000/0",
                         btns_level, btns_pulse, btns_any);
            end
        end
        rst      = 1'b0;
        btns_raw = '0;
        for (int k = 0; k < 9; k++) tick();
    endtask

    task automatic test_clean_press_release();
        logic [N-1:0] wl, wp;
        btns_raw[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            wl = (k >= 6) ? 5'b00001 : 5'b00000;
            wp = (k == 6 && ONESHOT) ? 5'b00001 : 5'b00000;
            total++;
            if (btns_level !== wl || btns_pulse !== wp || btns_any !== (k >= 6)) begin
                bad++;
                $display("FAIL press k=%0d: level=%b pulse=%b any=%b want %b/%b/%b",
                         k, btns_level, btns_pulse, btns_any, wl, wp, (k >= 6));
            end
        end
        btns_raw[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            wl = (k < 6) ? 5'b00001 : 5'b00000;
            total++;
            if (btns_level !== wl || btns_pulse !== 5'b00000 || btns_any !== (k < 6)) begin
                bad++;
                $display("FAIL release k=%0d: level=%b pulse=%b any=%b want %b/00000/%b",
                         k, btns_level, btns_pulse, btns_any, wl, (k < 6));
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        pat = 6'b101101;
        for (int k = 5; k >= 0; k--) begin
            btns_raw[1] = pat[k];
            tick();
        end
        btns_raw[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            total++;
            if (btns_level !== 5'b00000 || btns_pulse !== 5'b00000) begin
                bad++;
                $display("FAIL bounce k=%0d: level=%b pulse=%b want 00000/00000",
                         k, btns_level, btns_pulse);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] wl, wp;
        btns_raw = 5'b10101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            wl = (k >= 6) ? 5'b10101 : 5'b00000;
            wp = (k == 6 && ONESHOT) ? 5'b10101 : 5'b00000;
            total++;
            if (btns_level !== wl || btns_pulse !== wp) begin
                bad++;
                $display("FAIL simultaneous k=%0d: level=%b pulse=%b want %b/%b",
                         k, btns_level, btns_pulse, wl, wp);
            end
        end
        btns_raw = '0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_reset_mid_debounce();
        logic [N-1:0] wl, wp;
        btns_raw[2] = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            wl = (k >= 6) ? 5'b00100 : 5'b00000;
            wp = (k == 6 && ONESHOT) ? 5'b00100 : 5'b00000;
            total++;
            if (btns_level !== wl || btns_pulse !== wp) begin
                bad++;
                $display("FAIL reset_mid k=%0d: level=%b pulse=%b want %b/%b",
                         k, btns_level, btns_pulse, wl, wp);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (btns_level !== 5'b00000 || btns_pulse !== 5'b00000) begin
            bad++;
            $display("FAIL reset_pressed: level=%b pulse=%b want 00000/00000", btns_level, btns_pulse);
        end
        btns_raw = '0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_random();
        int hold [N];
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btns_raw[i] = ~btns_raw[i];
                    hold[i]     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                              : $urandom_range(1, 10);
                end else begin
                    hold[i]--;
                end
            end
            rst = ($urandom_range(0, 149) == 0);
            tick();
            total++;
            if (btns_level !== exp_level || btns_pulse !== exp_pulse || btns_any !== (|exp_level)) begin
                bad++;
                $display("FAIL random c=%0d: level=%b pulse=%b any=%b want %b/%b/%b",
                         c, btns_level, btns_pulse, btns_any, exp_level, exp_pulse, (|exp_level));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        btns_raw = '0;
        test_reset();
        test_clean_press_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid_debounce();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter N_BTNS, default 5: number of independent button channels.
REQ-002 The block SHALL have parameter DB_CYCLES, default 500000: consecutive stable clocks required to accept a level change; legal range 2 or greater.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port btns_raw, input, N_BTNS bits: asynchronous, bouncing board button inputs, active-high.
REQ-006 The block SHALL have port btns_level, output, N_BTNS bits: debounced button level.
REQ-007 The block SHALL have port btns_pulse, output, N_BTNS bits: one-clock pulse on each accepted press.
REQ-008 The block SHALL have port btns_any, output, 1 bit: OR of btns_level.

Function
REQ-009 Each btns_raw bit SHALL pass through a two-flop synchronizer; the second flop output is the sampled value s[i].
REQ-010 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter cnt of width $clog2(DB_CYCLES+1).
REQ-011 In IDLE, s=1 SHALL move the FSM to PRESS_WAIT with cnt=1; s=0 SHALL keep it in IDLE with cnt=0.
REQ-012 In PRESS_WAIT, s=0 SHALL return the FSM to IDLE with cnt=0 and no output change.
REQ-013 In PRESS_WAIT, s=1 with cnt=DB_CYCLES-1 SHALL move the FSM to PRESSED, set btns_level=1 and pulse btns_pulse for exactly one clock; s=1 otherwise SHALL increment cnt.
REQ-014 PRESSED/RELEASE_WAIT SHALL mirror REQ-011 to REQ-013 with s inverted; acceptance sets btns_level=0 and never generates a pulse.
REQ-015 Latency SHALL be exactly 2+DB_CYCLES clocks from a clean btns_raw transition to the btns_level change; any glitch shorter than DB_CYCLES sampled cycles SHALL be rejected.
REQ-016 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-017 A held button SHALL produce exactly one pulse per press, with no auto-repeat.
REQ-018 Channels SHALL be fully independent; simultaneous presses on several channels SHALL each produce their own pulse in the same cycle when their acceptance cycles coincide.
REQ-019 btns_level and btns_pulse SHALL be registered outputs; btns_any SHALL be combinational from btns_level.

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL clear the synchronizer flops, set all FSMs to IDLE, clear cnt, and drive btns_level=0 and btns_pulse=0 on the next cycle.
REQ-021 Reset asserted mid-debounce or while PRESSED SHALL abort the operation with no pulse.
REQ-022 A button held through reset deassertion SHALL be treated as a new press: after full latency, btns_level=1 with one pulse.

Configuration
REQ-023 With macro BTN_ONESHOT_EN defined, btns_pulse SHALL behave per REQ-013 and REQ-017.
REQ-024 With BTN_ONESHOT_EN undefined, btns_pulse SHALL be constant 0, no pulse logic SHALL be synthesized, and all other behaviour SHALL be unchanged.

Verification (DB_CYCLES=4, N_BTNS=5, BTN_ONESHOT_EN defined unless stated)
REQ-025 The bench SHALL check a clean press: btns_raw[0] goes 0->1 at cycle 10 and is held -> btns_level[0]=1 from cycle 16, btns_pulse[0]=1 only in cycle 16, btns_any=1.
REQ-026 The bench SHALL check bounce rejection: btns_raw[1] pattern 1,0,1,1,0,1 for one clock each, then 0 -> btns_level[1] stays 0 and no pulse occurs.
REQ-027 The bench SHALL check release: btns_raw[0] held high for 20 clocks, then 0 -> btns_level[0] falls 6 clocks after the release and no pulse occurs at release.
REQ-028 The bench SHALL check simultaneous presses: btns_raw=5'b10101 in one cycle -> btns_level=5'b10101 and btns_pulse=5'b10101 in the same cycle, 6 clocks later.
REQ-029 The bench SHALL check reset mid-debounce: btns_raw[2]=1 held, rst=1 for one clock at 2 clocks after the press -> no pulse at the original time, pulse 6 clocks after rst deasserts.
REQ-030 The bench SHALL check the build without the macro: repeat REQ-025 with BTN_ONESHOT_EN undefined -> btns_level identical, btns_pulse=0 throughout.
